sprite_line_engine: RTL and testbench

//  Per-scanline sprite evaluator/renderer. During each line it walks OAM, selects the sprites that cover the

---
 rtl/sprite_pkg.sv | 55 +++++
 rtl/sprite_linebuf.sv | 96 +++++++++
 rtl/sprite_line_engine.sv | 269 ++++++++++++++++++++++++++
 tb/tb_sprite_line_engine.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// Shared definitions for the sprite line engine.
// Holds the default geometry, the OAM attribute field layout, the evaluator
// state encoding and the line-buffer entry format.
package sprite_pkg;

    // Default geometry
    localparam int unsigned DEF_NUM_SPR      = 128;
    localparam int unsigned DEF_MAX_PER_LINE = 16;
    localparam int unsigned DEF_LINE_W       = 1024;

    // Sprite size is fixed at 8x8
    localparam int unsigned SPR_W = 8;
    localparam int unsigned SPR_H = 8;

    // Bus widths
    localparam int unsigned COORD_W = 11;
    localparam int unsigned ATTR_W  = 64;
    localparam int unsigned TILE_W  = 32;
    localparam int unsigned TADDR_W = 15;
    localparam int unsigned NAME_W  = 8;
    localparam int unsigned PAL_W   = 4;
    localparam int unsigned IDX_W   = 4;
    localparam int unsigned ROW_W   = 3;
    localparam int unsigned PIX_W   = 3;

    // Attribute word field offsets
    localparam int unsigned A_Y_LSB     = 0;
    localparam int unsigned A_X_LSB     = 11;
    localparam int unsigned A_ROTSCALE  = 22;
    localparam int unsigned A_DBL_DIS   = 23;
    localparam int unsigned A_FLIPX     = 32;
    localparam int unsigned A_FLIPY     = 33;
    localparam int unsigned A_NAME_LSB  = 36;
    localparam int unsigned A_PAL_LSB   = 44;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SCAN  = 3'd1,
        ST_EVAL  = 3'd2,
        ST_FETCH = 3'd3,
        ST_WRITE = 3'd4
    } state_t;

    typedef struct packed {
        logic             valid;
        logic [PAL_W-1:0] pal;
        logic [IDX_W-1:0] idx;
    } lb_entry_t;

    // Rot/scale sprites are always shown; otherwise bit 23 disables the sprite
    function automatic logic spr_enabled(input logic [ATTR_W-1:0] attr);
        return attr[A_ROTSCALE] | ~attr[A_DBL_DIS];
    endfunction

endpackage

// File: rtl/sprite_linebuf.sv
// Double-buffered sprite line buffer.
// Fill port writes one pixel per cycle into the bank not being displayed and
// never overwrites an entry that is already valid, so the first writer wins.
// Display port reads the display bank at rd_x, registers the result and clears
// the entry in the same cycle, leaving the bank empty for its next fill turn.
// Ports:
//   clk, reset_n          clock, async active-low reset
//   disp_bank             bank currently displayed (fill bank is the other)
//   wr_en/wr_col/wr_pal/wr_idx   fill write; idx 0 or col >= LINE_W is dropped
//   rd_x                  display column
//   pix_valid/pix_index/pix_pal  registered display pixel
module sprite_linebuf
    import sprite_pkg::*;
#(
    parameter int unsigned LINE_W = DEF_LINE_W
)(
    input  logic               clk,
    input  logic               reset_n,
    input  logic               disp_bank,
    input  logic               wr_en,
    input  logic [COORD_W:0]   wr_col,
    input  logic [PAL_W-1:0]   wr_pal,
    input  logic [IDX_W-1:0]   wr_idx,
    input  logic [COORD_W-1:0] rd_x,
    output logic               pix_valid,
    output logic [IDX_W-1:0]   pix_index,
    output logic [PAL_W-1:0]   pix_pal
);

    localparam int unsigned COL_W = $clog2(LINE_W);

    logic [LINE_W-1:0]            vld   [2];
    logic [PAL_W+IDX_W-1:0]       dmem  [2][LINE_W];

    logic                         fill_bank_c;
    logic [COL_W-1:0]             wcol_c;
    logic [COL_W-1:0]             rcol_c;
    logic                         wr_ok_c;
    logic                         rd_ok_c;
    lb_entry_t                    rd_e_c;

    assign fill_bank_c = ~disp_bank;
    assign wcol_c      = wr_col[COL_W-1:0];
    assign rcol_c      = rd_x[COL_W-1:0];
    assign rd_ok_c     = ({1'b0, rd_x} < (COORD_W+1)'(LINE_W));

    // Write only opaque, on-line pixels into columns nobody has claimed yet
    assign wr_ok_c = wr_en && (wr_idx != '0) && (wr_col < (COORD_W+1)'(LINE_W))
                     && !vld[fill_bank_c][wcol_c];

    // Display read of the current bank
    always_comb begin
        rd_e_c = '0;
        if (rd_ok_c) begin
            rd_e_c.valid = vld[disp_bank][rcol_c];
            rd_e_c.pal   = dmem[disp_bank][rcol_c][PAL_W+IDX_W-1:IDX_W];
            rd_e_c.idx   = dmem[disp_bank][rcol_c][IDX_W-1:0];
        end
    end

    // Valid bits: set by fill, cleared by display read (always different banks)
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld[0] <= '0;
            vld[1] <= '0;
        end else begin
            if (wr_ok_c) begin
                vld[fill_bank_c][wcol_c] <= 1'b1;
            end
            if (rd_ok_c) begin
                vld[disp_bank][rcol_c] <= 1'b0;
            end
        end
    end

    // Pixel payload storage, qualified by the valid bits
    always_ff @(posedge clk) begin
        if (wr_ok_c) begin
            dmem[fill_bank_c][wcol_c] <= {wr_pal, wr_idx};
        end
    end

    // Registered display outputs, zeroed for transparent columns
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pix_valid <= 1'b0;
            pix_index <= '0;
            pix_pal   <= '0;
        end else begin
            pix_valid <= rd_e_c.valid;
            pix_index <= rd_e_c.valid ? rd_e_c.idx : '0;
            pix_pal   <= rd_e_c.valid ? rd_e_c.pal : '0;
        end
    end

endmodule

// File: rtl/sprite_line_engine.sv
// Per-scanline sprite evaluator and renderer.
// Each line_start swaps the line-buffer banks and walks OAM for next_y; every
// hit fetches one tile row and paints 8 pixels into the fill bank while the
// display bank is streamed to the mixer at vga_x.
// Optional feature: define SPRITE_FLIP_EN to honour the flipx/flipy attributes.
// Ports:
//   clk, reset_n            clock, async active-low reset
//   line_start, next_y      start evaluation of next_y and swap banks
//   vga_x                   display column
//   oam_addr, oam_data      OAM read port, 1-cycle read latency
//   tile_req, tile_addr, tile_ack, tile_data   tile row fetch handshake
//   pix_valid, pix_index, pix_pal              display pixel to the mixer
//   busy, overflow          evaluation status; overflow sticky per line
module sprite_line_engine
    import sprite_pkg::*;
#(
    parameter int unsigned NUM_SPR      = DEF_NUM_SPR,
    parameter int unsigned MAX_PER_LINE = DEF_MAX_PER_LINE,
    parameter int unsigned LINE_W       = DEF_LINE_W,
    parameter int unsigned OAM_AW       = $clog2(NUM_SPR)
)(
    input  logic               clk,
    input  logic               reset_n,
    input  logic               line_start,
    input  logic [10:0]        next_y,
    input  logic [10:0]        vga_x,
    output logic [OAM_AW-1:0]  oam_addr,
    input  logic [63:0]        oam_data,
    output logic               tile_req,
    output logic [14:0]        tile_addr,
    input  logic               tile_ack,
    input  logic [31:0]        tile_data,
    output logic               pix_valid,
    output logic [3:0]         pix_index,
    output logic [3:0]         pix_pal,
    output logic               busy,
    output logic               overflow
);

    localparam int unsigned CNT_W = $clog2(MAX_PER_LINE + 1);

    // Registered state
    state_t              state_q,    state_d;
    logic [OAM_AW-1:0]   spr_i_q,    spr_i_d;
    logic [CNT_W-1:0]    hit_cnt_q,  hit_cnt_d;
    logic [COORD_W-1:0]  eval_y_q,   eval_y_d;
    logic                tile_req_q, tile_req_d;
    logic [TADDR_W-1:0]  tile_addr_q, tile_addr_d;
    logic                ack_pend_q, ack_pend_d;
    logic                busy_q,     busy_d;
    logic                ovf_q,      ovf_d;
    logic                disp_bank_q, disp_bank_d;
    logic [COORD_W-1:0]  spr_x_q,    spr_x_d;
    logic [PAL_W-1:0]    spr_pal_q,  spr_pal_d;
    logic                spr_fx_q,   spr_fx_d;
    logic [TILE_W-1:0]   tile_q,     tile_d;
    logic [PIX_W-1:0]    k_q,        k_d;

    // Attribute decode of the word returned for spr_i
    logic [COORD_W-1:0]  attr_y_c;
    logic [COORD_W-1:0]  attr_x_c;
    logic [NAME_W-1:0]   attr_name_c;
    logic [PAL_W-1:0]    attr_pal_c;
    logic                attr_fx_c;
    logic                attr_fy_c;
    logic [COORD_W-1:0]  dy_c;
    logic                hit_c;
    logic [ROW_W-1:0]    row_c;
    logic                last_c;
    logic                advance_c;

    // Fill write port
    logic                wr_en_c;
    logic [COORD_W:0]    wr_col_c;
    logic [PIX_W-1:0]    pix_sel_c;
    logic [IDX_W-1:0]    wr_idx_c;

    assign attr_y_c    = oam_data[A_Y_LSB +: COORD_W];
    assign attr_x_c    = oam_data[A_X_LSB +: COORD_W];
    assign attr_name_c = oam_data[A_NAME_LSB +: NAME_W];
    assign attr_pal_c  = oam_data[A_PAL_LSB +: PAL_W];

`ifdef SPRITE_FLIP_EN
    assign attr_fx_c = oam_data[A_FLIPX];
    assign attr_fy_c = oam_data[A_FLIPY];
    logic unused_attr;
    assign unused_attr = ^{oam_data[31:24], oam_data[35:34], oam_data[63:48]};
`else
    assign attr_fx_c = 1'b0;
    assign attr_fy_c = 1'b0;
    logic unused_attr;
    assign unused_attr = ^{oam_data[31:24], oam_data[35:32], oam_data[63:48]};
`endif

    // 11-bit wrapping distance from the sprite top to the line being built
    assign dy_c   = eval_y_q - attr_y_c;
    assign hit_c  = spr_enabled(oam_data) && (dy_c < COORD_W'(SPR_H));
    assign row_c  = dy_c[ROW_W-1:0] ^ {ROW_W{attr_fy_c}};
    assign last_c = (spr_i_q == OAM_AW'(NUM_SPR - 1));

    // Pixel k of the captured row, mirrored when flipx is latched
    assign pix_sel_c = k_q ^ {PIX_W{spr_fx_q}};
    assign wr_idx_c  = tile_q[{pix_sel_c, 2'b00} +: IDX_W];
    assign wr_col_c  = {1'b0, spr_x_q} + (COORD_W+1)'(k_q);

    // Next-state and datapath logic
    always_comb begin
        state_d     = state_q;
        spr_i_d     = spr_i_q;
        hit_cnt_d   = hit_cnt_q;
        eval_y_d    = eval_y_q;
        tile_req_d  = tile_req_q;
        tile_addr_d = tile_addr_q;
        ack_pend_d  = ack_pend_q;
        ovf_d       = ovf_q;
        disp_bank_d = disp_bank_q;
        spr_x_d     = spr_x_q;
        spr_pal_d   = spr_pal_q;
        spr_fx_d    = spr_fx_q;
        tile_d      = tile_q;
        k_d         = k_q;
        advance_c   = 1'b0;
        wr_en_c     = 1'b0;

        // A stale ack from an aborted fetch is swallowed here
        if (ack_pend_q && tile_ack) begin
            ack_pend_d = 1'b0;
        end

        unique case (state_q)
            ST_IDLE: begin
            end

            ST_SCAN: begin
                state_d = ST_EVAL;
            end

            ST_EVAL: begin
                if (hit_c) begin
                    if (hit_cnt_q == CNT_W'(MAX_PER_LINE)) begin
                        ovf_d   = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        spr_x_d     = attr_x_c;
                        spr_pal_d   = attr_pal_c;
                        spr_fx_d    = attr_fx_c;
                        tile_addr_d = TADDR_W'({attr_name_c, row_c, 3'b000});
                        // Hold off the request until any stale ack has drained
                        tile_req_d  = !(ack_pend_q && !tile_ack);
                        state_d     = ST_FETCH;
                    end
                end else begin
                    advance_c = 1'b1;
                end
            end

            ST_FETCH: begin
                if (ack_pend_q) begin
                    if (tile_ack) begin
                        tile_req_d = 1'b1;
                    end
                end else if (tile_req_q && tile_ack) begin
                    tile_d     = tile_data;
                    tile_req_d = 1'b0;
                    k_d        = '0;
                    state_d    = ST_WRITE;
                end
            end

            ST_WRITE: begin
                wr_en_c = 1'b1;
                k_d     = k_q + PIX_W'(1);
                if (k_q == PIX_W'(SPR_W - 1)) begin
                    hit_cnt_d = hit_cnt_q + CNT_W'(1);
                    advance_c = 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Move to the next OAM entry or finish the line
        if (advance_c) begin
            if (last_c) begin
                state_d = ST_IDLE;
            end else begin
                spr_i_d = spr_i_q + OAM_AW'(1);
                state_d = ST_SCAN;
            end
        end

        // line_start wins over everything: swap, clear, restart at entry 0
        if (line_start) begin
            state_d     = ST_SCAN;
            spr_i_d     = '0;
            hit_cnt_d   = '0;
            eval_y_d    = next_y;
            ovf_d       = 1'b0;
            disp_bank_d = ~disp_bank_q;
            tile_req_d  = 1'b0;
            wr_en_c     = 1'b0;
            ack_pend_d  = ((ack_pend_q || tile_req_q) && !tile_ack);
        end
    end

    always_comb busy_d = (state_d != ST_IDLE);

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            spr_i_q     <= '0;
            hit_cnt_q   <= '0;
            eval_y_q    <= '0;
            tile_req_q  <= 1'b0;
            tile_addr_q <= '0;
            ack_pend_q  <= 1'b0;
            busy_q      <= 1'b0;
            ovf_q       <= 1'b0;
            disp_bank_q <= 1'b0;
            spr_x_q     <= '0;
            spr_pal_q   <= '0;
            spr_fx_q    <= 1'b0;
            tile_q      <= '0;
            k_q         <= '0;
        end else begin
            state_q     <= state_d;
            spr_i_q     <= spr_i_d;
            hit_cnt_q   <= hit_cnt_d;
            eval_y_q    <= eval_y_d;
            tile_req_q  <= tile_req_d;
            tile_addr_q <= tile_addr_d;
            ack_pend_q  <= ack_pend_d;
            busy_q      <= busy_d;
            ovf_q       <= ovf_d;
            disp_bank_q <= disp_bank_d;
            spr_x_q     <= spr_x_d;
            spr_pal_q   <= spr_pal_d;
            spr_fx_q    <= spr_fx_d;
            tile_q      <= tile_d;
            k_q         <= k_d;
        end
    end

    assign oam_addr  = spr_i_q;
    assign tile_req  = tile_req_q;
    assign tile_addr = tile_addr_q;
    assign busy      = busy_q;
    assign overflow  = ovf_q;

    sprite_linebuf #(
        .LINE_W (LINE_W)
    ) u_linebuf (
        .clk       (clk),
        .reset_n   (reset_n),
        .disp_bank (disp_bank_q),
        .wr_en     (wr_en_c),
        .wr_col    (wr_col_c),
        .wr_pal    (spr_pal_q),
        .wr_idx    (wr_idx_c),
        .rd_x      (vga_x),
        .pix_valid (pix_valid),
        .pix_index (pix_index),
        .pix_pal   (pix_pal)
    );

endmodule

// File: tb/tb_sprite_line_engine.sv
// Directed bench for sprite_line_engine: single-sprite vector table plus
// hand-written overlap, overflow and mid-fetch abort sequences.
module tb_sprite_line_engine;
    import sprite_pkg::*;

    localparam int LW = int'(DEF_LINE_W);

    logic        clk;
    logic        reset_n;
    logic        line_start;
    logic [10:0] next_y;
    logic [10:0] vga_x;
    logic [6:0]  oam_addr;
    logic [63:0] oam_data;
    logic        tile_req;
    logic [14:0] tile_addr;
    logic        tile_ack;
    logic [31:0] tile_data;
    logic        pix_valid;
    logic [3:0]  pix_index;
    logic [3:0]  pix_pal;
    logic        busy;
    logic        overflow;

    sprite_line_engine dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .line_start (line_start),
        .next_y     (next_y),
        .vga_x      (vga_x),
        .oam_addr   (oam_addr),
        .oam_data   (oam_data),
        .tile_req   (tile_req),
        .tile_addr  (tile_addr),
        .tile_ack   (tile_ack),
        .tile_data  (tile_data),
        .pix_valid  (pix_valid),
        .pix_index  (pix_index),
        .pix_pal    (pix_pal),
        .busy       (busy),
        .overflow   (overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // OAM model: synchronous read, one cycle latency
    logic [63:0] oam_mem [128];
    always @(posedge clk) oam_data <= oam_mem[oam_addr];

    // Tile memory model: ack ack_lat cycles after a request is first seen
    logic [31:0] tile_by_name [256];
    int          ack_lat;
    int          n_req;
    logic [14:0] last_addr;

    initial begin : tile_resp
        int  cnt;
        logic in_flight;
        tile_ack  = 1'b0;
        tile_data = '0;
        in_flight = 1'b0;
        cnt       = 0;
        forever begin
            @(negedge clk);
            tile_ack = 1'b0;
            if (tile_req && !in_flight) begin
                in_flight = 1'b1;
                cnt       = 0;
                last_addr = tile_addr;
                n_req++;
            end
            if (in_flight) begin
                if (cnt >= ack_lat) begin
                    tile_ack  = 1'b1;
                    tile_data = tile_by_name[last_addr[13:6]];
                    in_flight = 1'b0;
                end else begin
                    cnt++;
                end
            end
        end
    end

    int n_vec;
    int n_bad;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] mk(input logic [10:0] y, input logic [10:0] x,
                                       input logic [7:0] nm, input logic [3:0] pal,
                                       input logic rs, input logic dd,
                                       input logic fx, input logic fy);
        logic [63:0] a;
        a = '0;
        a[10:0]  = y;
        a[21:11] = x;
        a[22]    = rs;
        a[23]    = dd;
        a[32]    = fx;
        a[33]    = fy;
        a[43:36] = nm;
        a[47:44] = pal;
        return a;
    endfunction

    task automatic clear_oam();
        for (int i = 0; i < 128; i++) oam_mem[i] = mk(11'd0, 11'd0, 8'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    // Expected display line
    logic       exp_v [LW];
    logic [3:0] exp_i [LW];
    logic [3:0] exp_p [LW];

    task automatic clear_exp();
        for (int c = 0; c < LW; c++) begin
            exp_v[c] = 1'b0;
            exp_i[c] = '0;
            exp_p[c] = '0;
        end
    endtask

    // Reference painter: opaque pixels only, first painter keeps the column
    task automatic paint_exp(input int x, input logic [31:0] d, input logic [3:0] pal, input logic fx);
        for (int k = 0; k < 8; k++) begin
            int col;
            logic [3:0] nib;
            col = x + k;
            nib = fx ? d[4*(7-k) +: 4] : d[4*k +: 4];
            if (col < LW && nib != 4'd0 && !exp_v[col]) begin
                exp_v[col] = 1'b1;
                exp_i[col] = nib;
                exp_p[col] = pal;
            end
        end
    endtask

    task automatic pulse(input logic [10:0] y);
        @(negedge clk);
        line_start = 1'b1;
        next_y     = y;
        @(negedge clk);
        line_start = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy && n < 4000) begin
            @(negedge clk);
            n++;
        end
        chk({name, " idle"}, 32'(busy), 32'd0);
    endtask

    // Walk every column once plus one off-line column; one comparison per line
    task automatic sweep(input string name);
        int bad;
        int fcol;
        logic [8:0] fact;
        logic [8:0] fexp;
        bad  = 0;
        fcol = -1;
        fact = '0;
        fexp = '0;
        for (int c = 0; c <= LW + 1; c++) begin
            @(negedge clk);
            if (c > 0) begin
                int pc;
                logic [8:0] act;
                logic [8:0] ex;
                pc  = c - 1;
                act = {pix_valid, pix_pal, pix_index};
                ex  = (pc < LW) ? {exp_v[pc], exp_p[pc], exp_i[pc]} : 9'd0;
                if (act !== ex) begin
                    if (bad == 0) begin
                        fcol = pc;
                        fact = act;
                        fexp = ex;
                    end
                    bad++;
                end
            end
            vga_x = (c < LW) ? 11'(c) : 11'd1500;
        end
        n_vec++;
        if (bad != 0) begin
            n_bad++;
            $display("FAIL %s: %0d bad columns, first col %0d got {v,pal,idx}=0x%0h expected 0x%0h",
                     name, bad, fcol, fact, fexp);
        end
    endtask

    typedef struct {
        logic [10:0] y;
        logic [10:0] x;
        logic [7:0]  nm;
        logic [3:0]  pal;
        logic        rs;
        logic        dd;
        logic        fx;
        logic        fy;
        logic [10:0] ny;
        logic [31:0] data;
        logic        exp_fetch;
        logic [14:0] exp_addr;
    } vec_t;

    localparam int NV = 9;
    vec_t vecs [NV];

    initial begin
        int n0;
        int n1;
        int n;
        logic fx_eff;

        n_vec = 0;
        n_bad = 0;
        n_req = 0;
        ack_lat = 0;
        reset_n = 1'b0;
        line_start = 1'b0;
        next_y = '0;
        vga_x = '0;
        clear_oam();
        for (int i = 0; i < 256; i++) tile_by_name[i] = '0;

        //          y        x        name    pal   rs    dd    fx    fy    next_y   data           fetch addr
        vecs[0] = '{11'd10,  11'd20,  8'h03, 4'h5, 1'b0, 1'b0, 1'b0, 1'b0, 11'd12,  32'h87654321, 1'b1, 15'h00D0};
        vecs[1] = '{11'd10,  11'd20,  8'h03, 4'h5, 1'b0, 1'b1, 1'b0, 1'b0, 11'd12,  32'h87654321, 1'b0, 15'h0000};
        vecs[2] = '{11'd0,   11'd1020,8'hFF, 4'hA, 1'b0, 1'b0, 1'b0, 1'b0, 11'd7,   32'h0F0E0D0C, 1'b1, 15'h3FF8};
        vecs[3] = '{11'd2045,11'd0,   8'h01, 4'h1, 1'b0, 1'b0, 1'b0, 1'b0, 11'd2,   32'h11111111, 1'b1, 15'h0068};
        vecs[4] = '{11'd10,  11'd20,  8'h03, 4'h5, 1'b0, 1'b0, 1'b0, 1'b0, 11'd18,  32'h87654321, 1'b0, 15'h0000};
        vecs[5] = '{11'd100, 11'd500, 8'h80, 4'hF, 1'b1, 1'b1, 1'b0, 1'b0, 11'd100, 32'h00000009, 1'b1, 15'h2000};
`ifdef SPRITE_FLIP_EN
        vecs[6] = '{11'd0,   11'd0,   8'h02, 4'h7, 1'b0, 1'b0, 1'b1, 1'b1, 11'd1,   32'h87654321, 1'b1, 15'h00B0};
`else
        vecs[6] = '{11'd0,   11'd0,   8'h02, 4'h7, 1'b0, 1'b0, 1'b1, 1'b1, 11'd1,   32'h87654321, 1'b1, 15'h0088};
`endif
        vecs[7] = '{11'd20,  11'd40,  8'h10, 4'h4, 1'b0, 1'b0, 1'b0, 1'b0, 11'd27,  32'hF0000000, 1'b1, 15'h0438};
        vecs[8] = '{11'd0,   11'd2045,8'h05, 4'h2, 1'b0, 1'b0, 1'b0, 1'b0, 11'd0,   32'h11111111, 1'b1, 15'h0140};

        repeat (3) @(negedge clk);
        chk("reset tile_req",  32'(tile_req),  32'd0);
        chk("reset oam_addr",  32'(oam_addr),  32'd0);
        chk("reset busy",      32'(busy),      32'd0);
        chk("reset overflow",  32'(overflow),  32'd0);
        chk("reset pix_valid", 32'(pix_valid), 32'd0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single-sprite vectors
        for (int v = 0; v < NV; v++) begin
            clear_oam();
            oam_mem[0] = mk(vecs[v].y, vecs[v].x, vecs[v].nm, vecs[v].pal,
                            vecs[v].rs, vecs[v].dd, vecs[v].fx, vecs[v].fy);
            tile_by_name[vecs[v].nm] = vecs[v].data;
            n0 = n_req;
            pulse(vecs[v].ny);
            wait_idle($sformatf("v%0d eval", v));
            chk($sformatf("v%0d fetch count", v), 32'(n_req - n0), 32'(vecs[v].exp_fetch));
            if (vecs[v].exp_fetch)
                chk($sformatf("v%0d tile_addr", v), 32'(last_addr), 32'(vecs[v].exp_addr));
            chk($sformatf("v%0d overflow", v), 32'(overflow), 32'd0);
            clear_oam();
            pulse(11'd0);
            wait_idle($sformatf("v%0d blank", v));
            clear_exp();
`ifdef SPRITE_FLIP_EN
            fx_eff = vecs[v].fx;
`else
            fx_eff = 1'b0;
`endif
            if (vecs[v].exp_fetch)
                paint_exp(int'(vecs[v].x), vecs[v].data, vecs[v].pal, fx_eff);
            sweep($sformatf("v%0d line", v));
        end

        // Overlap: lower OAM index keeps the shared columns
        clear_oam();
        oam_mem[0] = mk(11'd50, 11'd100, 8'd4, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        oam_mem[1] = mk(11'd50, 11'd104, 8'd5, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        tile_by_name[4] = 32'h11111111;
        tile_by_name[5] = 32'h22222222;
        n0 = n_req;
        pulse(11'd53);
        wait_idle("overlap eval");
        chk("overlap fetch count", 32'(n_req - n0), 32'd2);
        clear_oam();
        pulse(11'd0);
        wait_idle("overlap blank");
        clear_exp();
        paint_exp(100, 32'h11111111, 4'd2, 1'b0);
        paint_exp(104, 32'h22222222, 4'd3, 1'b0);
        sweep("overlap line");

        // Overflow: 20 hits, only the first 16 are rendered
        clear_oam();
        for (int i = 0; i < 20; i++) begin
            oam_mem[i] = mk(11'd200, 11'(i * 16), 8'(32 + i), 4'(i), 1'b0, 1'b0, 1'b0, 1'b0);
            tile_by_name[32 + i] = 32'h33333333;
        end
        n0 = n_req;
        pulse(11'd203);
        wait_idle("overflow eval");
        chk("overflow fetch count", 32'(n_req - n0), 32'd16);
        chk("overflow set", 32'(overflow), 32'd1);
        clear_oam();
        pulse(11'd0);
        chk("overflow cleared", 32'(overflow), 32'd0);
        wait_idle("overflow blank");
        clear_exp();
        for (int i = 0; i < 16; i++) paint_exp(i * 16, 32'h33333333, 4'(i), 1'b0);
        sweep("overflow line");

        // Abort during FETCH with a slow tile memory
        clear_oam();
        oam_mem[0] = mk(11'd300, 11'd10, 8'd9, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        tile_by_name[9] = 32'h44444444;
        ack_lat = 5;
        pulse(11'd300);
        n = 0;
        while (!tile_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("abort req raised", 32'(tile_req), 32'd1);
        line_start = 1'b1;
        next_y     = 11'd600;
        @(negedge clk);
        line_start = 1'b0;
        chk("abort req dropped", 32'(tile_req), 32'd0);
        chk("abort scan restart", 32'(oam_addr), 32'd0);
        chk("abort busy", 32'(busy), 32'd1);
        n1 = n_req;
        wait_idle("abort eval");
        repeat (10) @(negedge clk);
        chk("abort no refetch", 32'(n_req - n1), 32'd0);
        ack_lat = 0;
        clear_oam();
        pulse(11'd0);
        wait_idle("abort blank");
        clear_exp();
        sweep("abort line");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
